// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I control path: FSM states, opcode classes,
// ALU op selects, writeback selects and trap causes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  // Opcode class = IR[6:2]
  localparam logic [4:0] CLS_LOAD     = 5'b00000;
  localparam logic [4:0] CLS_MISC_MEM = 5'b00011;
  localparam logic [4:0] CLS_OP_IMM   = 5'b00100;
  localparam logic [4:0] CLS_AUIPC    = 5'b00101;
  localparam logic [4:0] CLS_STORE    = 5'b01000;
  localparam logic [4:0] CLS_OP       = 5'b01100;
  localparam logic [4:0] CLS_LUI      = 5'b01101;
  localparam logic [4:0] CLS_BRANCH   = 5'b11000;
  localparam logic [4:0] CLS_JALR     = 5'b11001;
  localparam logic [4:0] CLS_JAL      = 5'b11011;
  localparam logic [4:0] CLS_SYSTEM   = 5'b11100;

  localparam logic [1:0] ALU_CMP    = 2'b00;
  localparam logic [1:0] ALU_OPIMM  = 2'b01;
  localparam logic [1:0] ALU_ADD    = 2'b10;
  localparam logic [1:0] ALU_OP     = 2'b11;

  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_PC4     = 2'b10;
  localparam logic [1:0] WB_IMM     = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'b11;

  function automatic logic is_known_class(input logic [4:0] cls);
    logic known;
    case (cls)
      CLS_LOAD, CLS_MISC_MEM, CLS_OP_IMM, CLS_AUIPC, CLS_STORE, CLS_OP,
      CLS_LUI, CLS_BRANCH, CLS_JALR, CLS_JAL, CLS_SYSTEM: known = 1'b1;
      default:                                            known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Shared memory port handshake between the control unit and the memory arbiter.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_control_opclass_decode.sv
// Combinational RV32I opcode classifier, shared with the single-cycle control path.
module opclass_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [4:0] op_class,
  output logic       illegal
);

  always_comb begin
    op_class = opcode[6:2];
    illegal  = (opcode[1:0] != 2'b11) || !is_known_class(opcode[6:2]);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over a
// shared req/ack memory port, instret counting and sticky traps.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned MEM_TIMEOUT = 200,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [6:0]            opcode,
  input  logic                  branch_taken,
  multicycle_control_if.master  mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  reg_write,
  output logic                  imm_data,
  output logic                  alu_a_pc,
  output logic [1:0]            opcode_alu,
  output logic [1:0]            wb_sel,
  output logic                  retire,
  output logic [CNT_W-1:0]      instret,
  output logic                  busy,
  output logic                  trap,
  output logic [1:0]            trap_cause
);

  localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(MEM_TIMEOUT);

  state_t                state;
  state_t                state_next;
  logic [4:0]            cls_q;
  logic [4:0]            dec_class;
  logic                  dec_illegal;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic                  waiting;
  logic                  timeout;
  logic                  trap_set;
  logic [1:0]            cause_next;

  opclass_decode u_opclass_decode (
    .opcode   (opcode),
    .op_class (dec_class),
    .illegal  (dec_illegal)
  );

  // The counter holds the number of unacknowledged cycles already elapsed;
  // the cycle it equals MEM_TIMEOUT is the last chance for an ack to win.
  always_comb begin
    waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem.mem_ack;
    timeout = waiting && (wait_cnt == WAIT_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cls_q      <= '0;
      wait_cnt   <= '0;
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
      instret    <= '0;
    end else begin
      if (state == S_DECODE) begin
        cls_q <= dec_class;
      end
      wait_cnt <= (waiting && !timeout) ? wait_cnt + TIMEOUT_W'(1) : '0;
      if (trap_set) begin
        trap       <= 1'b1;
        trap_cause <= cause_next;
      end
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    trap_set   = 1'b0;
    cause_next = CAUSE_NONE;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem.mem_ack) begin
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
          trap_set   = 1'b1;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_next = S_TRAP;
          trap_set   = 1'b1;
          cause_next = CAUSE_ILLEGAL;
        end else if (dec_class == CLS_SYSTEM) begin
          state_next = S_TRAP;
          trap_set   = 1'b1;
          cause_next = CAUSE_SYSTEM;
        end else if (dec_class == CLS_MISC_MEM) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          CLS_BRANCH:           state_next = S_FETCH;
          CLS_LOAD, CLS_STORE:  state_next = S_MEM;
          default:              state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem.mem_ack) begin
          state_next = (cls_q == CLS_STORE) ? S_FETCH : S_WB;
        end else if (timeout) begin
          state_next = S_TRAP;
          trap_set   = 1'b1;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    reg_write        = 1'b0;
    imm_data         = 1'b0;
    alu_a_pc         = 1'b0;
    opcode_alu       = ALU_CMP;
    wb_sel           = WB_ALU;
    retire           = 1'b0;
    busy             = (state != S_IDLE) && (state != S_TRAP);
    case (state)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        // FENCE completes here; class is not latched yet, so use the live decode
        retire = !dec_illegal && (dec_class == CLS_MISC_MEM);
      end
      S_EXEC: begin
        case (cls_q)
          CLS_OP_IMM: begin
            imm_data   = 1'b1;
            opcode_alu = ALU_OPIMM;
          end
          CLS_OP: begin
            opcode_alu = ALU_OP;
          end
          CLS_LOAD, CLS_STORE, CLS_JALR: begin
            imm_data   = 1'b1;
            opcode_alu = ALU_ADD;
          end
          CLS_JAL, CLS_AUIPC: begin
            alu_a_pc   = 1'b1;
            imm_data   = 1'b1;
            opcode_alu = ALU_ADD;
          end
          CLS_BRANCH: begin
            opcode_alu = ALU_CMP;
            pc_write   = branch_taken;
            pc_src     = 1'b1;
            retire     = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = (cls_q == CLS_STORE);
        retire           = (cls_q == CLS_STORE) && mem.mem_ack;
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        case (cls_q)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR: begin
            wb_sel   = WB_PC4;
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          CLS_LUI:  wb_sel = WB_IMM;
          default:  wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-instruction cycle-list model
// predicts every output each cycle, plus literal spot checks between programs.
module tb_multicycle_control;

  localparam int TO = 5;
  localparam int CW = 4;

  localparam logic [4:0] K_LOAD   = 5'b00000;
  localparam logic [4:0] K_FENCE  = 5'b00011;
  localparam logic [4:0] K_OPIMM  = 5'b00100;
  localparam logic [4:0] K_AUIPC  = 5'b00101;
  localparam logic [4:0] K_STORE  = 5'b01000;
  localparam logic [4:0] K_OP     = 5'b01100;
  localparam logic [4:0] K_LUI    = 5'b01101;
  localparam logic [4:0] K_BRANCH = 5'b11000;
  localparam logic [4:0] K_JALR   = 5'b11001;
  localparam logic [4:0] K_JAL    = 5'b11011;
  localparam logic [4:0] K_SYSTEM = 5'b11100;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       imm_data;
    logic       alu_a_pc;
    logic [1:0] opcode_alu;
    logic [1:0] wb_sel;
    logic       retire;
    logic       busy;
  } ctl_t;

  typedef struct {
    logic          rs;
    logic          rn;
    logic          ak;
    logic          br;
    logic [6:0]    opc;
    bit            chk;
    ctl_t          exp;
    logic [CW-1:0] ins;
    logic          trp;
    logic [1:0]    cau;
  } cyc_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          branch_taken = 1'b0;
  logic [6:0]    opcode = 7'h00;
  logic          ir_write, pc_write, pc_src, reg_write, imm_data, alu_a_pc;
  logic [1:0]    opcode_alu, wb_sel;
  logic          retire, busy, trap;
  logic [CW-1:0] instret;
  logic [1:0]    trap_cause;

  multicycle_control_if mif();

  always #5 clk = ~clk;

  multicycle_control #(
    .TIMEOUT_W   (8),
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem          (mif),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .imm_data     (imm_data),
    .alu_a_pc     (alu_a_pc),
    .opcode_alu   (opcode_alu),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .instret      (instret),
    .busy         (busy),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  cyc_t          q[$];
  logic [CW-1:0] m_ins;
  logic          m_trap;
  logic [1:0]    m_cause;
  logic          g_run;
  logic [6:0]    g_opc;
  logic          g_br;
  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  int unsigned   n_cyc = 0;

  function automatic ctl_t actual();
    return {mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_write, pc_write, pc_src,
            reg_write, imm_data, alu_a_pc, opcode_alu, wb_sel, retire, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, n_cyc, got, exp);
    end
  endtask

  // Record one cycle of stimulus with the outputs it must produce; the model's
  // instret/trap state advances after the cycle, as registered outputs do.
  task automatic push(input logic rs, input logic ak, input ctl_t e, input bit chk);
    cyc_t c;
    c.rs = rs; c.rn = g_run; c.ak = ak; c.br = g_br; c.opc = g_opc;
    c.chk = chk; c.exp = e; c.ins = m_ins; c.trp = m_trap; c.cau = m_cause;
    q.push_back(c);
    if (e.retire) m_ins = m_ins + 1'b1;
    if (rs) begin
      m_ins = '0; m_trap = 1'b0; m_cause = 2'b00;
    end
  endtask

  task automatic idle(input logic rn, input logic rs);
    ctl_t e;
    e = '0;
    g_run = rn;
    push(rs, 1'b0, e, 1'b1);
  endtask

  task automatic instr(input logic [6:0] opc, input int fw, input int mw,
                       input logic br, input bit abort_mem);
    ctl_t e;
    logic [4:0] k;
    bit legal;
    int n;
    g_opc = opc; g_br = br; g_run = 1'b1;
    k = opc[6:2];
    legal = (opc[1:0] == 2'b11) &&
            (k inside {K_LOAD, K_FENCE, K_OPIMM, K_AUIPC, K_STORE, K_OP,
                       K_LUI, K_BRANCH, K_JALR, K_JAL, K_SYSTEM});
    // fetch: waits, then either the ack cycle or a timeout trap
    e = '0; e.mem_req = 1'b1; e.busy = 1'b1;
    n = (fw > TO) ? TO + 1 : fw;
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, e, 1'b1);
    if (fw > TO) begin m_trap = 1'b1; m_cause = 2'b10; return; end
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b0, 1'b1, e, 1'b1);
    // decode
    e = '0; e.busy = 1'b1; e.retire = legal && (k == K_FENCE);
    push(1'b0, 1'b0, e, 1'b1);
    if (!legal)         begin m_trap = 1'b1; m_cause = 2'b01; return; end
    if (k == K_SYSTEM)  begin m_trap = 1'b1; m_cause = 2'b11; return; end
    if (k == K_FENCE) return;
    // execute
    e = '0; e.busy = 1'b1;
    case (k)
      K_OPIMM:          begin e.imm_data = 1'b1; e.opcode_alu = 2'b01; end
      K_OP:             e.opcode_alu = 2'b11;
      K_LOAD, K_STORE,
      K_JALR:           begin e.imm_data = 1'b1; e.opcode_alu = 2'b10; end
      K_JAL, K_AUIPC:   begin e.alu_a_pc = 1'b1; e.imm_data = 1'b1; e.opcode_alu = 2'b10; end
      K_BRANCH:         begin e.pc_write = br; e.pc_src = 1'b1; e.retire = 1'b1; end
      default: ;
    endcase
    push(1'b0, 1'b0, e, 1'b1);
    if (k == K_BRANCH) return;
    if (k == K_LOAD || k == K_STORE) begin
      e = '0; e.busy = 1'b1; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
      e.mem_we = (k == K_STORE);
      n = (mw > TO) ? TO + 1 : mw;
      for (int i = 0; i < n; i++) begin
        if (abort_mem && i == 0) begin push(1'b1, 1'b0, e, 1'b1); return; end
        push(1'b0, 1'b0, e, 1'b1);
      end
      if (mw > TO) begin m_trap = 1'b1; m_cause = 2'b10; return; end
      e.retire = (k == K_STORE);
      push(1'b0, 1'b1, e, 1'b1);
      if (k == K_STORE) return;
    end
    // writeback
    e = '0; e.busy = 1'b1; e.reg_write = 1'b1; e.retire = 1'b1;
    case (k)
      K_LOAD:        e.wb_sel = 2'b01;
      K_JAL, K_JALR: begin e.wb_sel = 2'b10; e.pc_write = 1'b1; e.pc_src = 1'b1; end
      K_LUI:         e.wb_sel = 2'b11;
      default:       e.wb_sel = 2'b00;
    endcase
    push(1'b0, 1'b0, e, 1'b1);
  endtask

  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      rst = c.rs; run = c.rn; mif.mem_ack = c.ak; branch_taken = c.br; opcode = c.opc;
      #2;
      n_cyc++;
      if (c.chk) begin
        check("ctrl", 32'(actual()), 32'(c.exp));
        check("instret", 32'(instret), 32'(c.ins));
        check("trap", 32'({trap, trap_cause}), 32'({c.trp, c.cau}));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ctl_t z;
    z = '0;
    mif.mem_ack = 1'b0;
    m_ins = '0; m_trap = 1'b0; m_cause = 2'b00;
    g_run = 1'b0; g_opc = 7'h13; g_br = 1'b0;

    // reset, then ADDI with immediate ack
    push(1'b1, 1'b0, z, 1'b0);
    push(1'b1, 1'b0, z, 1'b1);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    instr(7'h13, 0, 0, 1'b0, 1'b0);
    run_q();
    check("addi_instret", 32'(instret), 32'd1);
    check("addi_busy", 32'(busy), 32'd1);

    // LW with 3-cycle data wait, then taken and untaken BEQ
    instr(7'h03, 0, 3, 1'b0, 1'b0);
    run_q();
    check("lw_instret", 32'(instret), 32'd2);
    instr(7'h63, 0, 0, 1'b1, 1'b0);
    instr(7'h63, 0, 0, 1'b0, 1'b0);
    run_q();
    check("beq_instret", 32'(instret), 32'd4);

    // remaining classes; last ADDI is acked in the timeout cycle
    instr(7'h23, 1, 0, 1'b0, 1'b0);
    instr(7'h33, 0, 0, 1'b0, 1'b0);
    instr(7'h37, 0, 0, 1'b0, 1'b0);
    instr(7'h17, 0, 0, 1'b0, 1'b0);
    instr(7'h6F, 0, 0, 1'b0, 1'b0);
    instr(7'h67, 0, 0, 1'b0, 1'b0);
    instr(7'h0F, 0, 0, 1'b0, 1'b0);
    instr(7'h13, TO, 0, 1'b0, 1'b0);
    run_q();
    check("mix_instret", 32'(instret), 32'd12);
    check("ack_wins_trap", 32'(trap), 32'd0);

    // illegal opcode traps, run pulses ignored, reset clears
    instr(7'h7F, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
    run_q();
    check("ill_trap", 32'(trap), 32'd1);
    check("ill_cause", 32'(trap_cause), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);
    run_q();
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_instret", 32'(instret), 32'd0);

    // fetch timeout, SYSTEM, illegal low bits
    idle(1'b1, 1'b0);
    instr(7'h13, TO + 1, 0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    run_q();
    check("to_cause", 32'(trap_cause), 32'd2);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    instr(7'h73, 0, 0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    run_q();
    check("sys_cause", 32'(trap_cause), 32'd3);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    instr(7'h12, 0, 0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    run_q();
    check("lowbits_cause", 32'(trap_cause), 32'd1);

    // reset while a data request is pending
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    instr(7'h13, 0, 0, 1'b0, 1'b0);
    instr(7'h03, 0, 2, 1'b0, 1'b1);
    run_q();
    check("abort_req", 32'(mif.mem_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_instret", 32'(instret), 32'd0);

    // data-phase timeout on a store
    idle(1'b1, 1'b0);
    instr(7'h23, 0, TO + 1, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    run_q();
    check("memto_cause", 32'(trap_cause), 32'd2);

    // instret wrap at 2^CW
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) instr(7'h0F, 0, 0, 1'b0, 1'b0);
    run_q();
    check("wrap_instret", 32'(instret), 32'd0);
    instr(7'h0F, 0, 0, 1'b0, 1'b0);
    run_q();
    check("wrap_next", 32'(instret), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle RV32I control unit; successor to the single-cycle combinational decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction over a shared memory port with a req/ack handshake.
- Emits per-state datapath controls, counts retired instructions, and traps on illegal opcodes, SYSTEM instructions or memory timeout.
- Sits between the IR/PC/regfile/ALU datapath and the memory arbiter.

Parameters:
- TIMEOUT_W, 8: width of the memory wait counter.
- MEM_TIMEOUT, 200: maximum unacknowledged cycles before trap; must be less than 2^TIMEOUT_W.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  leave IDLE and start fetching.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- branch_taken  in  1  datapath compare result; valid in EXEC.
- mem_ack  in  1  memory completes the pending request this cycle.
- mem_req  out  1  memory request; held until ack.
- mem_we  out  1  store request.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = ALU result.
- reg_write  out  1  regfile write enable.
- imm_data  out  1  ALU B operand = immediate.
- alu_a_pc  out  1  ALU A operand = old PC.
- opcode_alu  out  2  01 = op_imm, 11 = op, 10 = add, 00 = compare.
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = old PC+4, 11 = immediate.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count.
- busy  out  1  state is neither IDLE nor TRAP.
- trap  out  1  sticky trap indication.
- trap_cause  out  2  01 = illegal, 10 = timeout, 11 = SYSTEM.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset: state goes to IDLE; instret, wait counter, trap and trap_cause clear to 0.
- Outputs are Moore decodes of state plus the latched opcode class. Every output is 0 in IDLE and in TRAP, except trap, trap_cause and instret.
- Reset mid-request: mem_req falls in the cycle after rst is sampled. The memory side must tolerate an abandoned request.
- IDLE: go to FETCH when run=1.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - On mem_ack: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - If mem_ack arrives in the same cycle the wait counter reaches MEM_TIMEOUT, the ack wins.
- DECODE:
  - Latch class = opcode[6:2].
  - Illegal: opcode[1:0] != 11, or an unlisted class. Go to TRAP with cause 01.
  - SYSTEM (11100): go to TRAP with cause 11.
  - MISC_MEM (00011): FENCE is a no-op; retire and go to FETCH.
  - All other classes go to EXEC.
- EXEC, by class:
  - OP_IMM (00100): imm_data=1, opcode_alu=01, then WB.
  - OP (01100): opcode_alu=11, then WB.
  - LOAD (00000) / STORE (01000): imm_data=1, opcode_alu=10, then MEM.
  - BRANCH (11000): opcode_alu=00; pc_write=branch_taken, pc_src=1; retire; then FETCH.
  - JAL (11011): alu_a_pc=1, imm_data=1, opcode_alu=10, then WB.
  - JALR (11001): imm_data=1, opcode_alu=10, then WB.
  - AUIPC (00101): alu_a_pc=1, imm_data=1, opcode_alu=10, then WB.
  - LUI (01101): straight to WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=(class==STORE).
  - On ack: a store retires and goes to FETCH; a load goes to WB.
- WB:
  - reg_write=1; retire; then FETCH.
  - wb_sel: LOAD=01, JAL/JALR=10, LUI=11, all others 00.
  - JAL/JALR also assert pc_write=1 and pc_src=1.
- Wait counter:
  - Increments each FETCH or MEM cycle with mem_req=1 and mem_ack=0; clears on ack.
  - At MEM_TIMEOUT with no ack: go to TRAP with cause 10.
- Counting: instret += 1 on each retire pulse and wraps at 2^CNT_W.
- TRAP: sticky until rst; run is ignored.
- Latency with zero-wait ack (cycles FETCH to FETCH):
  - FENCE: 2
  - BRANCH: 3
  - OP, OP_IMM, LUI, AUIPC, JAL, JALR, STORE: 4
  - LOAD: 5

Decomposition:
- Package rv_ctrl_pkg holds:
  - state enum;
  - opcode class constants (5-bit);
  - opcode_alu, wb_sel and trap_cause encodings.
- One sub-module, opclass_decode: combinational. Input opcode[6:0]; outputs class and an illegal flag. Reused by the single-cycle control path.

Test Plan:
- rst, then run=1, fetch ADDI (0x13) with ack on first request -> DECODE/EXEC(imm_data=1, opcode_alu=01)/WB(reg_write=1, wb_sel=00); retire once; instret=1 at cycle 4.
- LW (0x03) with data ack delayed 3 cycles -> mem_req held 4 cycles with mem_addr_sel=1 and mem_we=0; WB wb_sel=01; FETCH to FETCH = 8 cycles.
- BEQ (0x63): branch_taken=1 -> pc_write=1, pc_src=1 in EXEC. branch_taken=0 -> pc_write=0. Both retire in 3 cycles.
- Opcode 0x7F -> TRAP, trap_cause=01, busy=0. Later run pulses are ignored; rst restores IDLE and trap=0.
- Withhold mem_ack in FETCH with MEM_TIMEOUT=5 -> trap_cause=10 after 5 waiting cycles. Ack in the timeout cycle instead -> no trap.
- Assert rst while in MEM with mem_req=1 -> next cycle mem_req=0, state IDLE, instret=0.
